hsp_collector: RTL and testbench

Collects finished ungapped extensions (high-scoring segment pairs, HSPs) from the seed-extension stage and delivers them to the host-side result writer. On each completion pulse it captures `{locationStart, locationEnd, Score}`, then drops the result if it is malformed, below threshold, or a duplicate of the last accepted HSP. Survivors are buffered in a small FIFO behind a valid/ready output. A full flag lets the extension controller withhold its next `start`.

---
 rtl/hsp_collector.sv | 130 +++++++++++++
 tb/tb_hsp_collector.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsp_collector.sv
// HSP result collector: edge-triggered capture, filter (malformed / threshold / duplicate)
// and a show-ahead FIFO behind a valid/ready port.
module hsp_collector #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [10:0] minScore,
  input  logic        extStop,
  input  logic [31:0] extStart,
  input  logic [31:0] extEnd,
  input  logic [10:0] extScore,
  output logic        full,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] outStart,
  output logic [31:0] outEnd,
  output logic [10:0] outScore,
  output logic [15:0] acceptCount,
  output logic [15:0] dropCount,
  output logic        overflow
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic        stopQ, capV;
  logic [31:0] capStart, capEnd;
  logic [10:0] capScore, capMin;

  logic        lastV;
  logic [31:0] lastStart, lastEnd;

  logic [74:0]   mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;
  logic [74:0]   head;

  logic malformed, lowScore, dup, accept, drop, pop, push;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stopQ    <= 1'b0;
      capV     <= 1'b0;
      capStart <= '0;
      capEnd   <= '0;
      capScore <= '0;
      capMin   <= '0;
    end else if (clear) begin
      stopQ <= 1'b0;
      capV  <= 1'b0;
    end else begin
      stopQ <= extStop;
      capV  <= extStop & ~stopQ;
      if (extStop & ~stopQ) begin
        capStart <= extStart;
        capEnd   <= extEnd;
        capScore <= extScore;
        capMin   <= minScore;
      end
    end
  end

  // First matching drop reason wins; only the accept/drop outcome matters downstream.
  always_comb begin
    malformed = capEnd < capStart;
    lowScore  = capScore < capMin;
    dup       = lastV && (capStart == lastStart) && (capEnd == lastEnd);
    accept    = capV && !malformed && !lowScore && !dup;
    drop      = capV && !accept;
    pop       = outValid && outReady;
    push      = accept && (!full || pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      lastV       <= 1'b0;
      lastStart   <= '0;
      lastEnd     <= '0;
      acceptCount <= '0;
      dropCount   <= '0;
      overflow    <= 1'b0;
    end else if (clear) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      lastV       <= 1'b0;
      acceptCount <= '0;
      dropCount   <= '0;
      overflow    <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_ONE;
      if (pop)  rdPtr <= rdPtr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (accept) begin
        lastV     <= 1'b1;
        lastStart <= capStart;
        lastEnd   <= capEnd;
        if (acceptCount != '1) acceptCount <= acceptCount + 16'd1;
        if (!push) overflow <= 1'b1;
      end
      if (drop && dropCount != '1) dropCount <= dropCount + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wrPtr] <= {capStart, capEnd, capScore};
  end

  // Data is gated so the unreset memory never shows through while empty.
  always_comb begin
    head     = mem[rdPtr];
    full     = count == FULL_CNT;
    outValid = count != '0;
    outStart = outValid ? head[74:43] : '0;
    outEnd   = outValid ? head[42:11] : '0;
    outScore = outValid ? head[10:0]  : '0;
  end

endmodule

// File: tb/tb_hsp_collector.sv
// Self-checking bench for hsp_collector: directed tables, corner sequences and a
// randomized run against a queue-based reference model.
module tb_hsp_collector;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic [10:0] minScore = '0;
  logic        extStop = 1'b0;
  logic [31:0] extStart = '0;
  logic [31:0] extEnd = '0;
  logic [10:0] extScore = '0;
  logic        full, outValid;
  logic        outReady = 1'b0;
  logic [31:0] outStart, outEnd;
  logic [10:0] outScore;
  logic [15:0] acceptCount, dropCount;
  logic        overflow;

  always #5 clk = ~clk;

  hsp_collector #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .minScore(minScore),
    .extStop(extStop), .extStart(extStart), .extEnd(extEnd), .extScore(extScore),
    .full(full), .outValid(outValid), .outReady(outReady),
    .outStart(outStart), .outEnd(outEnd), .outScore(outScore),
    .acceptCount(acceptCount), .dropCount(dropCount), .overflow(overflow)
  );

  typedef struct packed {
    logic [31:0] s;
    logic [31:0] e;
    logic [10:0] sc;
  } ent_t;

  typedef struct {
    logic [31:0] s;
    logic [31:0] e;
    logic [10:0] sc;
    logic [10:0] ms;
    logic [15:0] acc;
    logic [15:0] drp;
  } vec_t;

  int   nCmp = 0;
  int   nFail = 0;
  int   popCnt = 0;
  bit   randRdy = 1'b0;
  ent_t q[$];
  ent_t lastPop;

  logic        mLastV;
  logic [31:0] mLastS, mLastE;
  logic [15:0] mAcc, mDrp;
  logic        mOvf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One clock; every consumed head entry is compared with the reference queue front.
  task automatic tick;
    ent_t got;
    @(negedge clk);
    if (rst && outValid && outReady && !clear) begin
      got = {outStart, outEnd, outScore};
      nCmp++;
      if (q.size() == 0) begin
        nFail++;
        $display("FAIL pop_unexpected: got %0h, want no entry", got);
      end else begin
        if (got !== q[0]) begin
          nFail++;
          $display("FAIL pop_data: got %0h, want %0h", got, q[0]);
        end
        void'(q.pop_front());
      end
      popCnt++;
      lastPop = got;
    end
    @(posedge clk);
    #1;
    if (randRdy) outReady = 1'($urandom_range(0, 1));
  endtask

  task automatic modelReset;
    q.delete();
    mLastV = 1'b0;
    mLastS = '0;
    mLastE = '0;
    mAcc   = '0;
    mDrp   = '0;
    mOvf   = 1'b0;
    popCnt = 0;
  endtask

  task automatic modelHsp(input logic [31:0] s, input logic [31:0] e, input logic [10:0] sc);
    if (e < s || sc < minScore || (mLastV && s == mLastS && e == mLastE)) begin
      if (mDrp != 16'hFFFF) mDrp++;
    end else begin
      if (mAcc != 16'hFFFF) mAcc++;
      mLastV = 1'b1;
      mLastS = s;
      mLastE = e;
      if (q.size() >= DEPTH && !outReady) mOvf = 1'b1;
      else q.push_back({s, e, sc});
    end
  endtask

  task automatic hsp(input logic [31:0] s, input logic [31:0] e, input logic [10:0] sc);
    extStart = s;
    extEnd   = e;
    extScore = sc;
    extStop  = 1'b1;
    tick;
    extStop = 1'b0;
    modelHsp(s, e, sc);
    tick;
  endtask

  task automatic settle;
    repeat (3) tick;
  endtask

  task automatic doClear;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    modelReset;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    outReady = 1'b1;
    while (outValid && n < 8 * DEPTH) begin
      tick;
      n++;
    end
    chk({name, "_drained"}, outValid, 0);
  endtask

  task automatic chkResetOutputs(input string tag);
    chk({tag, "_full"},     full, 0);
    chk({tag, "_outValid"}, outValid, 0);
    chk({tag, "_outStart"}, outStart, 0);
    chk({tag, "_outEnd"},   outEnd, 0);
    chk({tag, "_outScore"}, outScore, 0);
    chk({tag, "_accept"},   acceptCount, 0);
    chk({tag, "_drop"},     dropCount, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  vec_t vec[8];

  initial begin
    logic [31:0] s, e, ps, pe;
    logic [10:0] sc;

    vec[0] = '{32'd10, 32'd31, 11'd49,   11'd50,   16'd1, 16'd1};
    vec[1] = '{32'd10, 32'd31, 11'd50,   11'd50,   16'd2, 16'd1};
    vec[2] = '{32'd10, 32'd31, 11'd50,   11'd50,   16'd2, 16'd2};
    vec[3] = '{32'd40, 32'd20, 11'd99,   11'd50,   16'd2, 16'd3};
    vec[4] = '{32'd10, 32'd32, 11'd50,   11'd50,   16'd3, 16'd3};
    vec[5] = '{32'd5,  32'd5,  11'd0,    11'd0,    16'd4, 16'd3};
    vec[6] = '{32'd7,  32'd7,  11'd100,  11'd2047, 16'd4, 16'd4};
    vec[7] = '{32'd7,  32'd7,  11'd2047, 11'd2047, 16'd5, 16'd4};

    modelReset;
    repeat (3) tick;
    chkResetOutputs("reset");
    rst = 1'b1;
    tick;
    tick;

    // Single HSP: latency N+1 not yet visible, N+2 visible.
    minScore = 11'd40;
    outReady = 1'b1;
    extStart = 32'd1000;
    extEnd   = 32'd1043;
    extScore = 11'd60;
    extStop  = 1'b1;
    tick;
    extStop = 1'b0;
    modelHsp(32'd1000, 32'd1043, 11'd60);
    chk("single_n1_valid", outValid, 0);
    tick;
    chk("single_n2_valid", outValid, 1);
    chk("single_start", outStart, 1000);
    chk("single_end", outEnd, 1043);
    chk("single_score", outScore, 60);
    tick;
    chk("single_accept", acceptCount, 1);
    chk("single_drop", dropCount, 0);

    for (int i = 0; i < 8; i++) begin
      minScore = vec[i].ms;
      hsp(vec[i].s, vec[i].e, vec[i].sc);
      settle;
      chk($sformatf("filter%0d_accept", i), acceptCount, vec[i].acc);
      chk($sformatf("filter%0d_drop", i), dropCount, vec[i].drp);
    end
    chk("filter_pops", popCnt, 5);

    // Fill, overflow by one, then drain in order.
    doClear;
    chk("clear_accept", acceptCount, 0);
    chk("clear_drop", dropCount, 0);
    outReady = 1'b0;
    minScore = 11'd40;
    for (int i = 0; i < DEPTH; i++) hsp(32'(i * 100), 32'(i * 100 + 50), 11'(100 + i));
    settle;
    chk("fill_full", full, 1);
    chk("fill_valid", outValid, 1);
    hsp(32'd5000, 32'd5050, 11'd200);
    settle;
    chk("ovf_flag", overflow, 1);
    chk("ovf_full", full, 1);
    chk("ovf_accept", acceptCount, DEPTH + 1);
    chk("ovf_drop", dropCount, 0);
    drain("ovf");
    chk("ovf_pops", popCnt, DEPTH);
    chk("ovf_full_after", full, 0);

    // Push and pop on the same edge while full.
    doClear;
    outReady = 1'b0;
    for (int i = 0; i < DEPTH; i++) hsp(32'(i * 10 + 7), 32'(i * 10 + 9), 11'(300 + i));
    settle;
    chk("sim_full_before", full, 1);
    extStart = 32'd9000;
    extEnd   = 32'd9100;
    extScore = 11'd300;
    extStop  = 1'b1;
    tick;
    extStop  = 1'b0;
    outReady = 1'b1;
    modelHsp(32'd9000, 32'd9100, 11'd300);
    tick;
    outReady = 1'b0;
    chk("sim_full_after", full, 1);
    chk("sim_overflow", overflow, 0);
    chk("sim_accept", acceptCount, DEPTH + 1);
    settle;
    drain("sim");
    chk("sim_pops", popCnt, DEPTH + 1);
    chk("sim_last_start", lastPop.s, 9000);
    chk("sim_last_end", lastPop.e, 9100);
    chk("sim_last_score", lastPop.sc, 300);

    // Randomized wrap-around run with a random consumer.
    doClear;
    randRdy = 1'b1;
    ps = 32'd0;
    pe = 32'd0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      minScore = 11'($urandom_range(0, 200));
      case ($urandom_range(0, 9))
        0: begin
          s = 32'($urandom_range(100, 1000000));
          e = s - 32'($urandom_range(1, 50));
        end
        1: begin
          s = ps;
          e = pe;
        end
        default: begin
          s = 32'($urandom_range(0, 32'h7FFF_0000));
          e = s + 32'($urandom_range(0, 5000));
        end
      endcase
      sc = 11'($urandom_range(0, 2047));
      hsp(s, e, sc);
      ps = s;
      pe = e;
      repeat ($urandom_range(0, 2)) tick;
    end
    settle;
    randRdy = 1'b0;
    drain("wrap");
    chk("wrap_accept", acceptCount, mAcc);
    chk("wrap_drop", dropCount, mDrp);
    chk("wrap_overflow", overflow, mOvf);
    chk("wrap_leftover", q.size(), 0);

    // Held extStop, async reset mid-drain, then clear and re-accept.
    doClear;
    outReady = 1'b0;
    minScore = 11'd0;
    extStart = 32'd1;
    extEnd   = 32'd2;
    extScore = 11'd100;
    extStop  = 1'b1;
    tick;
    modelHsp(32'd1, 32'd2, 11'd100);
    repeat (4) tick;
    extStop = 1'b0;
    settle;
    chk("hold_accept", acceptCount, 1);
    chk("hold_drop", dropCount, 0);
    hsp(32'd3, 32'd4, 11'd100);
    chk("hold_two_valid", outValid, 1);
    outReady = 1'b1;
    tick;
    #2;
    rst = 1'b0;
    #1;
    chkResetOutputs("midrst");
    modelReset;
    tick;
    rst = 1'b1;
    tick;
    doClear;
    chk("post_clear_accept", acceptCount, 0);
    chk("post_clear_drop", dropCount, 0);
    hsp(32'd1, 32'd2, 11'd100);
    settle;
    chk("reaccept_accept", acceptCount, 1);
    chk("reaccept_drop", dropCount, 0);
    drain("reaccept");
    chk("reaccept_pops", popCnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
